xgmii_rx_decoder: RTL and testbench
===================================

# xgmii_rx_decoder

Receive-side XGMII decoder that converts a 64-bit/8-lane XGMII stream (as driven onto `xgmii_txd`/`xgmii_txc` by the MAC transmitter) back into the packet interface format (`pkt_rx_*`: sop/eop/val/mod/err). It sits at the far end of the MAC's transmit path as a reference receiver and checker, letting the bench run without the loopback shortcut. It strips start and preamble, detects terminate, realigns the end of frame, and flags framing and length errors.

## Interface
Parameters:
- `MIN_LEN`, 64: minimum legal frame length in bytes (post-SFD, incl. FCS).
- `MAX_LEN`, 1518: maximum legal frame length in bytes.

Ports:
- `clk_156m25`  in  1  single clock for the block.
- `reset_156m25`  in  1  reset; synchronous, active-high.
- `xgmii_rxd`  in  64  XGMII data; lane k = bits [8k+7:8k].
- `xgmii_rxc`  in  8  XGMII control; bit k = 1 marks lane k as a control character.
- `pkt_rx_data`  out  64  frame data; first byte (lane 0) in [63:56].
- `pkt_rx_val`  out  1  output word valid, one-cycle strobe per word.
- `pkt_rx_sop`  out  1  first word of frame, qualified by `val`.
- `pkt_rx_eop`  out  1  last word of frame, qualified by `val`.
- `pkt_rx_mod`  out  3  valid bytes in eop word mod 8; 0 = all 8 valid.
- `pkt_rx_err`  out  1  frame error; asserted only with `eop`.
- `stat_frames_good`  out  32  good-frame counter (see Configuration).
- `stat_frames_bad`  out  32  bad/dropped-frame counter (see Configuration).

## Operation
- Start is recognised only in lane 0: `rxc[0]=1`, lane0=0xFB. The same word must hold `rxc[7:1]=0`, lanes1–6=0x55 and lane7=0xD5. Otherwise the preamble is bad.
- FSM states:
  - IDLE → DATA on a good start.
  - IDLE → DROP on a start with a bad preamble; `stat_frames_bad`+1.
  - DATA → IDLE on terminate.
  - DROP → IDLE on terminate; DROP produces no output.
- Terminate: the lowest lane k with `rxc[k]=1` and lane=0xFD.
  - k=0: the held word is emitted with eop, mod=0.
  - k>0: the held word is emitted as a normal word, then lanes 0..k-1 are emitted as the eop word with mod=k; unused bytes are 0.
- One-word hold register. Each full data word waits one cycle so eop can be attached when the following word is terminate in lane 0.
- Error conditions in DATA; each sets a sticky error flag reported on eop:
  - Control lane below the terminate lane with value ≠0xFD, including 0xFE.
  - Byte count < `MIN_LEN` at terminate.
  - Byte count > `MAX_LEN`. The frame still runs to terminate.
- Byte counter: 14 bits, saturating; +8 per full word, +k on terminate.
- Start (lane0=0xFB control) while in DATA:
  - The held word is emitted with eop=1, err=1, mod=0.
  - The new start is then processed as if in IDLE during the same cycle.
- Idle/other control words in IDLE are ignored.
- There is no backpressure; the downstream must accept every `val` strobe.
- Counters: on each eop, `stat_frames_good`+1 if err=0, else `stat_frames_bad`+1. Both counters saturate at 0xFFFFFFFF.

## Timing
- All outputs are registered.
- Reset values: `pkt_rx_data`=0, `val`/`sop`/`eop`/`err`=0, `mod`=0, counters=0, FSM=IDLE, hold register empty.
- Reset mid-frame: outputs are 0 after the next edge, no eop is emitted, and the frame is discarded.
- Latency: a data word sampled at edge N appears on the outputs after edge N+1.
  - Exception: a terminate-lane-0 word emits nothing; the held word carries eop after that edge.
- `sop` is on the first data word after start. A one-word frame has sop and eop on the same word.
- The start word itself is never emitted.
- Back-to-back frames are allowed: the terminate word sampled at M and a start word at M+1 are both handled, so the next sop follows without a gap cycle.

## Configuration
- `XGMII_RX_DEC_STATS_EN`:
  - Defined: both 32-bit saturating counters are implemented.
  - Undefined: `stat_frames_good`/`stat_frames_bad` are tied to 0, no counter flops are built, and all other behaviour is identical.

## Test plan
- Good 64-byte frame:
  - Stimulus: start word, 8 data words 0x00..0x3F (lane order), then terminate in lane 0.
  - Expected: 8 `val` strobes, sop on the first with data 0x0001020304050607, eop with mod=0, err=0; good count=1.
- Partial tail, 67 bytes:
  - Stimulus: terminate in lane 3 after 8 full words.
  - Expected: 9 words; the last has mod=3, data 0x404142_0000000000, eop, err=0.
- Bad preamble:
  - Stimulus: lane7=0xD4.
  - Expected: no `val` for the frame; bad count=1; the next good frame decodes normally.
- Errors:
  - Stimulus A: 0xFE control in lane 2 of the 3rd word of a 100-byte frame. Expected: eop with err=1.
  - Stimulus B: a 40-byte frame. Expected: err=1 due to `MIN_LEN`.
  - Expected overall: bad count=2.
- Start while in DATA:
  - Stimulus: start after 4 data words, then a good 64-byte frame.
  - Expected: word 4 emitted with eop, err=1, mod=0; the next frame decodes normally with sop on its first word.
- Reset and saturation:
  - Stimulus: assert `reset_156m25` for one cycle mid-frame.
  - Expected: all outputs 0 the next cycle and no eop. With the macro defined, forcing the counter to 0xFFFFFFFF and sending a good frame keeps it at 0xFFFFFFFF.

Source files
------------

// File: rtl/xgmii_rx_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : xgmii_rx_decoder                                           |
// | Description : Reference XGMII receiver. Turns a 64-bit/8-lane XGMII      |
// |               stream back into sop/eop/val/mod/err packet words. It      |
// |               strips start and preamble, finds terminate, realigns the   |
// |               frame tail, and flags framing and length errors.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk_156m25        in   1   block clock                                 |
// |   reset_156m25      in   1   synchronous active-high reset               |
// |   xgmii_rxd         in  64   XGMII data, lane k = [8k+7:8k]              |
// |   xgmii_rxc         in   8   XGMII control, bit k flags lane k           |
// |   pkt_rx_data       out 64   frame data, lane 0 byte in [63:56]          |
// |   pkt_rx_val        out  1   word strobe                                 |
// |   pkt_rx_sop        out  1   first word of frame                         |
// |   pkt_rx_eop        out  1   last word of frame                          |
// |   pkt_rx_mod        out  3   valid bytes in eop word mod 8               |
// |   pkt_rx_err        out  1   frame error, only with eop                  |
// |   stat_frames_good  out 32   saturating good-frame counter               |
// |   stat_frames_bad   out 32   saturating bad/dropped-frame counter        |
// | Build option                                                             |
// |   XGMII_RX_DEC_STATS_EN : when defined, the two frame counters are built;|
// |                           otherwise both stat outputs are tied to 0.     |
// +--------------------------------------------------------------------------+
module xgmii_rx_decoder #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk_156m25,
  input  logic        reset_156m25,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  output logic [63:0] pkt_rx_data,
  output logic        pkt_rx_val,
  output logic        pkt_rx_sop,
  output logic        pkt_rx_eop,
  output logic [2:0]  pkt_rx_mod,
  output logic        pkt_rx_err,
  output logic [31:0] stat_frames_good,
  output logic [31:0] stat_frames_bad
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam logic [7:0]  C_START   = 8'hFB;
  localparam logic [7:0]  C_TERM    = 8'hFD;
  localparam logic [7:0]  C_PRE     = 8'h55;
  localparam logic [7:0]  C_SFD     = 8'hD5;
  localparam logic [13:0] C_CNT_MAX = 14'h3FFF;

  state_e      state_q, state_d;
  logic [63:0] hold_data_q, hold_data_d;
  logic        hold_vld_q, hold_vld_d;
  logic        hold_sop_q, hold_sop_d;
  logic        hold_last_q, hold_last_d;
  logic        hold_err_q, hold_err_d;
  logic [2:0]  hold_mod_q, hold_mod_d;
  logic [13:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [63:0] data_q, data_d;
  logic        val_q, val_d, sop_q, sop_d, eop_q, eop_d, oerr_q, oerr_d;
  logic [2:0]  mod_q, mod_d;

  // Word decode
  logic        w_is_start, w_pre_ok, w_term_found, w_ctrl_err, w_len_err;
  logic [2:0]  w_term_lane;
  logic [7:0]  w_below_mask;
  logic [63:0] w_swapped, w_tail;
  logic [14:0] w_total;

  always_comb begin
    w_is_start = xgmii_rxc[0] && (xgmii_rxd[7:0] == C_START);
    w_pre_ok   = (xgmii_rxc[7:1] == 7'd0) && (xgmii_rxd[63:56] == C_SFD);
    for (int i = 1; i < 7; i++) begin
      if (xgmii_rxd[8*i +: 8] != C_PRE) w_pre_ok = 1'b0;
    end
    // Descending scan so the lowest terminate lane wins.
    w_term_found = 1'b0;
    w_term_lane  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == C_TERM)) begin
        w_term_found = 1'b1;
        w_term_lane  = 3'(i);
      end
    end
    // Any control lane ahead of terminate (or anywhere, without one) is an error.
    w_below_mask = w_term_found ? ((8'd1 << w_term_lane) - 8'd1) : 8'hFF;
    w_ctrl_err   = |(xgmii_rxc & w_below_mask);
    w_swapped    = '0;
    w_tail       = '0;
    for (int i = 0; i < 8; i++) begin
      w_swapped[63-8*i -: 8] = xgmii_rxd[8*i +: 8];
      if (i < int'(w_term_lane)) w_tail[63-8*i -: 8] = xgmii_rxd[8*i +: 8];
    end
    w_total   = {1'b0, cnt_q} + {12'd0, w_term_lane};
    w_len_err = (w_total < 15'(MIN_LEN)) || (w_total > 15'(MAX_LEN));
  end

  // Next-state logic
  logic       w_emit, w_emit_eop, w_emit_err, w_take_start, w_good_inc;
  logic [2:0] w_emit_mod;
  logic [1:0] w_bad_inc;

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_vld_d   = hold_vld_q;
    hold_sop_d   = hold_sop_q;
    hold_last_d  = hold_last_q;
    hold_err_d   = hold_err_q;
    hold_mod_d   = hold_mod_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    w_emit       = 1'b0;
    w_emit_eop   = 1'b0;
    w_emit_err   = 1'b0;
    w_emit_mod   = 3'd0;
    w_take_start = 1'b0;
    w_bad_inc    = 2'd0;

    // A partial tail left by terminate in lane k>0 drains one cycle later,
    // concurrently with whatever the FSM does with the current word.
    if (hold_vld_q && hold_last_q) begin
      w_emit      = 1'b1;
      w_emit_eop  = 1'b1;
      w_emit_err  = hold_err_q;
      w_emit_mod  = hold_mod_q;
      hold_vld_d  = 1'b0;
      hold_last_d = 1'b0;
    end

    case (state_q)
      ST_DATA: begin
        if (w_is_start) begin
          // New start inside a frame: close the current one as errored.
          if (hold_vld_q) begin
            w_emit     = 1'b1;
            w_emit_eop = 1'b1;
            w_emit_err = 1'b1;
          end
          hold_vld_d   = 1'b0;
          w_take_start = 1'b1;
        end else if (w_term_found) begin
          state_d = ST_IDLE;
          if (w_term_lane == 3'd0) begin
            hold_vld_d = 1'b0;
            if (hold_vld_q) begin
              w_emit     = 1'b1;
              w_emit_eop = 1'b1;
              w_emit_err = err_q | w_ctrl_err | w_len_err;
            end else begin
              // Start immediately followed by terminate: nothing to deliver.
              w_bad_inc = 2'd1;
            end
          end else begin
            w_emit      = hold_vld_q;
            hold_data_d = w_tail;
            hold_vld_d  = 1'b1;
            hold_sop_d  = (cnt_q == 14'd0);
            hold_last_d = 1'b1;
            hold_mod_d  = w_term_lane;
            hold_err_d  = err_q | w_ctrl_err | w_len_err;
          end
        end else begin
          w_emit      = hold_vld_q;
          hold_data_d = w_swapped;
          hold_vld_d  = 1'b1;
          hold_sop_d  = (cnt_q == 14'd0);
          hold_last_d = 1'b0;
          err_d       = err_q | w_ctrl_err;
          cnt_d       = (cnt_q > C_CNT_MAX - 14'd8) ? C_CNT_MAX : cnt_q + 14'd8;
        end
      end
      ST_DROP: begin
        // A fresh start also ends a dropped frame so a lost terminate cannot wedge us.
        if (w_is_start)        w_take_start = 1'b1;
        else if (w_term_found) state_d      = ST_IDLE;
      end
      default: begin
        if (w_is_start) w_take_start = 1'b1;
      end
    endcase

    if (w_take_start) begin
      cnt_d = 14'd0;
      err_d = 1'b0;
      if (w_pre_ok) begin
        state_d = ST_DATA;
      end else begin
        state_d   = ST_DROP;
        w_bad_inc = w_bad_inc + 2'd1;
      end
    end

    w_good_inc = w_emit && w_emit_eop && !w_emit_err;
    if (w_emit && w_emit_eop && w_emit_err) w_bad_inc = w_bad_inc + 2'd1;

    data_d = w_emit ? hold_data_q : 64'd0;
    val_d  = w_emit;
    sop_d  = w_emit && hold_sop_q;
    eop_d  = w_emit_eop;
    mod_d  = w_emit_mod;
    oerr_d = w_emit_err;
  end

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state_q     <= ST_IDLE;
      hold_data_q <= '0;
      hold_vld_q  <= 1'b0;
      hold_sop_q  <= 1'b0;
      hold_last_q <= 1'b0;
      hold_err_q  <= 1'b0;
      hold_mod_q  <= 3'd0;
      cnt_q       <= 14'd0;
      err_q       <= 1'b0;
      data_q      <= '0;
      val_q       <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      mod_q       <= 3'd0;
      oerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_vld_q  <= hold_vld_d;
      hold_sop_q  <= hold_sop_d;
      hold_last_q <= hold_last_d;
      hold_err_q  <= hold_err_d;
      hold_mod_q  <= hold_mod_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      data_q      <= data_d;
      val_q       <= val_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      mod_q       <= mod_d;
      oerr_q      <= oerr_d;
    end
  end

  assign pkt_rx_data = data_q;
  assign pkt_rx_val  = val_q;
  assign pkt_rx_sop  = sop_q;
  assign pkt_rx_eop  = eop_q;
  assign pkt_rx_mod  = mod_q;
  assign pkt_rx_err  = oerr_q;

`ifdef XGMII_RX_DEC_STATS_EN
  logic [31:0] stat_good_q, stat_bad_q;
  logic [32:0] w_good_sum, w_bad_sum;

  assign w_good_sum = {1'b0, stat_good_q} + {32'd0, w_good_inc};
  assign w_bad_sum  = {1'b0, stat_bad_q} + {31'd0, w_bad_inc};

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      stat_good_q <= '0;
      stat_bad_q  <= '0;
    end else begin
      stat_good_q <= w_good_sum[32] ? 32'hFFFF_FFFF : w_good_sum[31:0];
      stat_bad_q  <= w_bad_sum[32] ? 32'hFFFF_FFFF : w_bad_sum[31:0];
    end
  end

  assign stat_frames_good = stat_good_q;
  assign stat_frames_bad  = stat_bad_q;
`else
  logic w_unused_stats;
  assign w_unused_stats   = w_good_inc ^ (|w_bad_inc);
  assign stat_frames_good = 32'd0;
  assign stat_frames_bad  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xgmii_rx_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_xgmii_rx_decoder                                        |
// | Description : Scoreboard bench for xgmii_rx_decoder. Expected packet     |
// |               words are queued as frames are driven and compared as the  |
// |               decoder emits them; frame counters follow a small model.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_xgmii_rx_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [63:0] pkt_rx_data;
  logic        pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err;
  logic [2:0]  pkt_rx_mod;
  logic [31:0] stat_frames_good, stat_frames_bad;

  always #5 clk = ~clk;

  xgmii_rx_decoder #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk_156m25       (clk),
    .reset_156m25     (reset),
    .xgmii_rxd        (xgmii_rxd),
    .xgmii_rxc        (xgmii_rxc),
    .pkt_rx_data      (pkt_rx_data),
    .pkt_rx_val       (pkt_rx_val),
    .pkt_rx_sop       (pkt_rx_sop),
    .pkt_rx_eop       (pkt_rx_eop),
    .pkt_rx_mod       (pkt_rx_mod),
    .pkt_rx_err       (pkt_rx_err),
    .stat_frames_good (stat_frames_good),
    .stat_frames_bad  (stat_frames_bad)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
  } exp_t;

  localparam logic [63:0] IDLE_W = {8{8'h07}};

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_good = 32'd0;
  logic [31:0] exp_bad  = 32'd0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (pkt_rx_val === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_val", {63'd0, pkt_rx_val}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("word_data", pkt_rx_data, e.data);
        check_eq("word_ctl", {58'd0, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err},
                 {58'd0, e.sop, e.eop, e.mod, e.err});
      end
    end
  end

  // Lane i carries byte (base + i).
  function automatic logic [63:0] lane_word(input int base);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'(base + i);
    return d;
  endfunction

  // Packet order: lane 0 goes to the top byte.
  function automatic logic [63:0] to_pkt(input logic [63:0] d);
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[63-8*i -: 8] = d[8*i +: 8];
    return p;
  endfunction

  task automatic send(input logic [63:0] d, input logic [7:0] c);
    xgmii_rxd = d;
    xgmii_rxc = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idles(input int n);
    repeat (n) send(IDLE_W, 8'hFF);
  endtask

  task automatic send_start(input logic [7:0] sfd);
    send({sfd, {6{8'h55}}, 8'hFB}, 8'h01);
  endtask

  // Full frame of nbytes; optional 0xFE control in lane 2 of word inj_word.
  task automatic send_frame(input int nbytes, input int inj_word, input bit bad_pre);
    int          full;
    int          rem;
    bit          ferr;
    logic [63:0] d, e;
    logic [7:0]  c;
    exp_t        x;
    full = nbytes / 8;
    rem  = nbytes % 8;
    ferr = (nbytes < 64) || (nbytes > 1518) || (inj_word >= 0);
    send_start(bad_pre ? 8'hD4 : 8'hD5);
    for (int w = 0; w < full; w++) begin
      d = lane_word(w * 8);
      c = 8'h00;
      if (w == inj_word) begin
        d[23:16] = 8'hFE;
        c[2]     = 1'b1;
      end
      if (!bad_pre) begin
        x.data = to_pkt(d);
        x.sop  = (w == 0);
        x.eop  = (rem == 0) && (w == full - 1);
        x.mod  = 3'd0;
        x.err  = x.eop && ferr;
        sb_q.push_back(x);
      end
      send(d, c);
    end
    d = IDLE_W;
    c = 8'hFF;
    e = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (i < rem) begin
        d[8*i +: 8]    = 8'(full * 8 + i);
        c[i]           = 1'b0;
        e[63-8*i -: 8] = 8'(full * 8 + i);
      end else if (i == rem) begin
        d[8*i +: 8] = 8'hFD;
      end
    end
    if (rem > 0 && !bad_pre) begin
      x = '{data: e, sop: (full == 0), eop: 1'b1, mod: 3'(rem), err: ferr};
      sb_q.push_back(x);
    end
    send(d, c);
    if (bad_pre || ferr) exp_bad  = exp_bad + 32'd1;
    else                 exp_good = (exp_good == 32'hFFFF_FFFF) ? exp_good : exp_good + 32'd1;
  endtask

  // Start plus n data words, left open; the next start aborts it.
  task automatic send_open(input int n);
    exp_t x;
    send_start(8'hD5);
    for (int w = 0; w < n; w++) begin
      x = '{data: to_pkt(lane_word(w * 8)), sop: (w == 0), eop: (w == n - 1),
            mod: 3'd0, err: (w == n - 1)};
      sb_q.push_back(x);
      send(lane_word(w * 8), 8'h00);
    end
    exp_bad = exp_bad + 32'd1;
  endtask

  task automatic check_stats(input string tag);
`ifdef XGMII_RX_DEC_STATS_EN
    check_eq({tag, "_good"}, {32'd0, stat_frames_good}, {32'd0, exp_good});
    check_eq({tag, "_bad"}, {32'd0, stat_frames_bad}, {32'd0, exp_bad});
`else
    check_eq({tag, "_good"}, {32'd0, stat_frames_good}, 64'd0);
    check_eq({tag, "_bad"}, {32'd0, stat_frames_bad}, 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    reset     = 1'b1;
    xgmii_rxd = IDLE_W;
    xgmii_rxc = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", pkt_rx_data, 64'd0);
    check_eq("rst_ctl", {57'd0, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err}, 64'd0);
    check_stats("rst");
    reset = 1'b0;
    idles(2);

    // Good 64-byte frame, then a 67-byte frame with a 3-byte tail.
    send_frame(64, -1, 1'b0);
    idles(3);
    check_stats("good64");
    send_frame(67, -1, 1'b0);
    idles(3);
    check_stats("tail67");

    // Bad preamble is dropped; the next frame decodes normally.
    send_frame(64, -1, 1'b1);
    idles(2);
    send_frame(64, -1, 1'b0);
    idles(3);
    check_stats("badpre");

    // Control error in a 100-byte frame, then a runt.
    send_frame(100, 2, 1'b0);
    idles(3);
    send_frame(40, -1, 1'b0);
    idles(3);
    check_stats("errors");

    // Start inside a frame, immediately followed by a good frame.
    send_open(4);
    send_frame(64, -1, 1'b0);
    idles(3);
    check_stats("abort");

    // Back-to-back frames, the first with a 6-byte tail.
    send_frame(70, -1, 1'b0);
    send_frame(64, -1, 1'b0);
    send_frame(72, -1, 1'b0);
    idles(3);
    check_stats("b2b");

    // Reset mid-frame: words 0 and 1 come out, word 2 is still held.
    send_start(8'hD5);
    for (int w = 0; w < 3; w++) begin
      if (w < 2) begin
        x = '{data: to_pkt(lane_word(w * 8)), sop: (w == 0), eop: 1'b0, mod: 3'd0, err: 1'b0};
        sb_q.push_back(x);
      end
      send(lane_word(w * 8), 8'h00);
    end
    reset = 1'b1;
    send(lane_word(24), 8'h00);
    reset    = 1'b0;
    exp_good = 32'd0;
    exp_bad  = 32'd0;
    check_eq("midrst_data", pkt_rx_data, 64'd0);
    check_eq("midrst_ctl", {57'd0, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err}, 64'd0);
    check_eq("midrst_sb", 64'(sb_q.size()), 64'd0);
    for (int w = 4; w < 8; w++) send(lane_word(w * 8), 8'h00);
    send({IDLE_W[63:8], 8'hFD}, 8'hFF);
    idles(3);
    check_stats("midrst");
    send_frame(64, -1, 1'b0);
    idles(3);
    check_stats("postrst");

`ifdef XGMII_RX_DEC_STATS_EN
    force dut.stat_good_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.stat_good_q;
    exp_good = 32'hFFFF_FFFF;
    send_frame(64, -1, 1'b0);
    idles(3);
    check_stats("sat");
`endif

    idles(2);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
